systemizer_stream_ctrl: RTL and testbench

//  Front/back-end controller for the systemizer. Accepts the public-key matrix as a

---
 rtl/systemizer_stream_ctrl_if.sv | 39 +++
 rtl/systemizer_stream_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_systemizer_stream_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/systemizer_stream_ctrl_if.sv
// Bus bundle for the systemizer stream controller: upstream matrix stream,
// systemizer memory/control port and downstream matrix stream.
interface systemizer_stream_ctrl_if #(
    parameter int W  = 20,
    parameter int AW = 12
);
    // Valid/ready: a word moves on a rising edge where valid && ready are both high;
    // the sender keeps valid and data stable until that edge, ready may change freely.
    logic          s_valid;
    logic          s_ready;
    logic [W-1:0]  s_data;

    logic          sys_wr_en;
    logic [AW-1:0] sys_wr_addr;
    logic [W-1:0]  sys_data_in;
    logic          sys_start;
    logic          sys_success;
    logic          sys_fail;
    logic          sys_rd_en;
    logic [AW-1:0] sys_rd_addr;
    logic [W-1:0]  sys_data_out;

    logic          m_valid;
    logic          m_ready;
    logic [W-1:0]  m_data;
    logic          m_last;

    modport master (
        input  s_valid, s_data, sys_success, sys_fail, sys_data_out, m_ready,
        output s_ready, sys_wr_en, sys_wr_addr, sys_data_in, sys_start,
               sys_rd_en, sys_rd_addr, m_valid, m_data, m_last
    );

    modport slave (
        output s_valid, s_data, sys_success, sys_fail, sys_data_out, m_ready,
        input  s_ready, sys_wr_en, sys_wr_addr, sys_data_in, sys_start,
               sys_rd_en, sys_rd_addr, m_valid, m_data, m_last
    );
endinterface

// File: rtl/systemizer_stream_ctrl.sv
// Load / systemize / unload job controller for the systemizer core.
// Optional macro SYSCTRL_RETRY_EN: retry a failed systemization up to MAX_RETRY times.
module systemizer_stream_ctrl #(
    parameter int N         = 20,
    parameter int M         = 1,
    parameter int L         = 200,
    parameter int K         = 400,
    parameter int MAX_RETRY = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_start,
    systemizer_stream_ctrl_if.master bus,
    output logic                     busy,
    output logic                     done,
    output logic                     status_fail,
    output logic [2:0]               dbg_state
`ifdef SYSCTRL_RETRY_EN
    ,
    output logic                     retry_req
`endif
);
    localparam int W     = N * M;
    localparam int DEPTH = L * K / N;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_START  = 3'd2,
        S_WAIT   = 3'd3,
        S_UNLOAD = 3'd4
    } state_t;

    state_t        state_q;
    logic [AW-1:0] wr_cnt_q;
    logic [AW-1:0] rd_cnt_q;
    logic          rd_done_q;
    logic          pend_q;
    logic          pend_last_q;
    logic [W-1:0]  fifo_data_q [2];
    logic [1:0]    fifo_last_q;
    logic          wr_ptr_q;
    logic          rd_ptr_q;
    logic [1:0]    occ_q;
    logic [1:0]    occ_d;
    logic          done_q;
    logic          fail_q;
    logic          wr_hs;
    logic          pop;
    logic          rd_en;
    logic          m_valid_w;

`ifdef SYSCTRL_RETRY_EN
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    logic [RW-1:0] attempt_q;
    logic          retry_q;
    assign retry_req = retry_q;
`endif

    always_comb begin
        wr_hs     = (state_q == S_LOAD) && bus.s_valid;
        m_valid_w = (occ_q != 2'd0);
        pop       = m_valid_w && bus.m_ready;
        // Occupancy after this cycle's returning read and pop; crediting the pop keeps
        // one word per cycle flowing while m_ready stays high.
        occ_d     = occ_q + {1'b0, pend_q} - {1'b0, pop};
        rd_en     = (state_q == S_UNLOAD) && !rd_done_q && (occ_d < 2'd2);
    end

    assign bus.s_ready     = (state_q == S_LOAD);
    assign bus.sys_wr_en   = wr_hs;
    assign bus.sys_wr_addr = wr_cnt_q;
    assign bus.sys_data_in = wr_hs ? bus.s_data : '0;
    assign bus.sys_start   = (state_q == S_START);
    assign bus.sys_rd_en   = rd_en;
    assign bus.sys_rd_addr = rd_cnt_q;
    assign bus.m_valid     = m_valid_w;
    assign bus.m_data      = fifo_data_q[rd_ptr_q];
    assign bus.m_last      = m_valid_w && fifo_last_q[rd_ptr_q];
    assign busy            = (state_q != S_IDLE);
    assign done            = done_q;
    assign status_fail     = fail_q;
    assign dbg_state       = state_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            wr_cnt_q       <= '0;
            rd_cnt_q       <= '0;
            rd_done_q      <= 1'b0;
            pend_q         <= 1'b0;
            pend_last_q    <= 1'b0;
            fifo_data_q[0] <= '0;
            fifo_data_q[1] <= '0;
            fifo_last_q    <= '0;
            wr_ptr_q       <= 1'b0;
            rd_ptr_q       <= 1'b0;
            occ_q          <= '0;
            done_q         <= 1'b0;
            fail_q         <= 1'b0;
`ifdef SYSCTRL_RETRY_EN
            attempt_q      <= '0;
            retry_q        <= 1'b0;
`endif
        end else begin
            done_q      <= 1'b0;
`ifdef SYSCTRL_RETRY_EN
            retry_q     <= 1'b0;
`endif
            pend_q      <= rd_en;
            pend_last_q <= rd_en && (rd_cnt_q == LAST);
            occ_q       <= occ_d;
            if (pend_q) begin
                fifo_data_q[wr_ptr_q] <= bus.sys_data_out;
                fifo_last_q[wr_ptr_q] <= pend_last_q;
                wr_ptr_q              <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            if (rd_en) begin
                rd_cnt_q <= rd_cnt_q + 1'b1;
                if (rd_cnt_q == LAST) rd_done_q <= 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    if (cmd_start) begin
                        wr_cnt_q  <= '0;
                        fail_q    <= 1'b0;
`ifdef SYSCTRL_RETRY_EN
                        attempt_q <= '0;
`endif
                        state_q   <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (wr_hs) begin
                        if (wr_cnt_q == LAST) begin
                            wr_cnt_q <= '0;
                            state_q  <= S_START;
                        end else begin
                            wr_cnt_q <= wr_cnt_q + 1'b1;
                        end
                    end
                end
                S_START: state_q <= S_WAIT;
                S_WAIT: begin
                    if (bus.sys_fail) begin
`ifdef SYSCTRL_RETRY_EN
                        if (attempt_q < RW'(MAX_RETRY)) begin
                            attempt_q <= attempt_q + 1'b1;
                            retry_q   <= 1'b1;
                            wr_cnt_q  <= '0;
                            state_q   <= S_LOAD;
                        end else begin
                            fail_q  <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= S_IDLE;
                        end
`else
                        fail_q  <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
`endif
                    end else if (bus.sys_success) begin
                        rd_cnt_q  <= '0;
                        rd_done_q <= 1'b0;
                        state_q   <= S_UNLOAD;
                    end
                end
                S_UNLOAD: begin
                    if (pop && fifo_last_q[rd_ptr_q]) begin
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_systemizer_stream_ctrl.sv
// Directed bench for systemizer_stream_ctrl with a behavioural systemizer memory
// and an expected-word queue on the output stream.
module tb_systemizer_stream_ctrl;
    localparam int N     = 4;
    localparam int M     = 1;
    localparam int L     = 8;
    localparam int K     = 16;
    localparam int W     = N * M;
    localparam int DEPTH = L * K / N;
    localparam int AW    = $clog2(DEPTH);

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_start;
    logic       busy;
    logic       done;
    logic       status_fail;
    logic [2:0] dbg_state;
`ifdef SYSCTRL_RETRY_EN
    logic       retry_req;
`endif

    systemizer_stream_ctrl_if #(.W(W), .AW(AW)) bus ();

    systemizer_stream_ctrl #(
        .N(N), .M(M), .L(L), .K(K), .MAX_RETRY(3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_start   (cmd_start),
        .bus         (bus),
        .busy        (busy),
        .done        (done),
        .status_fail (status_fail),
        .dbg_state   (dbg_state)
`ifdef SYSCTRL_RETRY_EN
        ,
        .retry_req   (retry_req)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural systemizer memory: write same edge, read data one cycle later.
    logic [W-1:0] sys_mem [DEPTH];
    always @(posedge clk) begin
        if (bus.sys_wr_en) sys_mem[bus.sys_wr_addr] <= bus.sys_data_in;
        if (bus.sys_rd_en) bus.sys_data_out <= sys_mem[bus.sys_rd_addr];
    end

    int checks   = 0;
    int failures = 0;
    int n_start = 0, n_done = 0, n_wr = 0, n_rd = 0, n_retry = 0;
    int out_idx = 0, wr_exp = 0, rd_exp = 0;
    int s0, d0, w0, r0, q0, t, cyc;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] e;
    logic         stall_pend = 1'b0;
    logic [W-1:0] stall_data;
    logic         stall_last;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output-side scoreboard and event counters, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (bus.sys_start) n_start++;
            if (done) begin
                n_done++;
                check("done_not_busy", busy, 0);
                check("done_vs_start", bus.sys_start, 0);
            end
            if (bus.sys_wr_en) begin
                check("wr_addr", bus.sys_wr_addr, wr_exp);
                check("wr_data", bus.sys_data_in, bus.s_data);
                wr_exp = (wr_exp + 1) % DEPTH;
                n_wr++;
            end
            if (bus.sys_rd_en) begin
                check("rd_addr", bus.sys_rd_addr, rd_exp);
                rd_exp++;
                n_rd++;
            end
`ifdef SYSCTRL_RETRY_EN
            if (retry_req) n_retry++;
`endif
            if (stall_pend) begin
                check("stall_valid", bus.m_valid, 1);
                check("stall_data", bus.m_data, stall_data);
                check("stall_last", bus.m_last, stall_last);
            end
            if (bus.m_valid && bus.m_ready) begin
                check("out_avail", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("out_data", bus.m_data, e);
                end
                check("out_last", bus.m_last, out_idx == DEPTH - 1);
                out_idx++;
            end
            stall_pend = bus.m_valid && !bus.m_ready;
            stall_data = bus.m_data;
            stall_last = bus.m_last;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic snap();
        s0 = n_start; d0 = n_done; w0 = n_wr; r0 = n_rd; q0 = n_retry;
    endtask

    task automatic new_job();
        out_idx = 0; rd_exp = 0; wr_exp = 0;
        cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
    endtask

    task automatic load(input int base, input bit gaps, input bit keep, input bit poke);
        int w;
        for (int i = 0; i < DEPTH; i++) begin
            if (gaps) begin
                while ($urandom_range(0, 2) == 0) begin
                    bus.s_valid = 1'b0;
                    tick();
                end
            end
            bus.s_valid = 1'b1;
            bus.s_data  = W'(base + 3 * i);
            cmd_start   = poke && (i == 5);
            w = 0;
            while (!bus.s_ready && w < 100) begin
                tick();
                w++;
            end
            if (w >= 100) begin
                check("load_ready_timeout", bus.s_ready, 1);
                break;
            end
            if (keep) exp_q.push_back(bus.s_data);
            tick();
        end
        bus.s_valid = 1'b0;
        cmd_start   = 1'b0;
    endtask

    task automatic outcome(input bit succ, input bit fl, input bit poke);
        int w = 0;
        while (bus.sys_start !== 1'b1 && w < 200) begin
            tick();
            w++;
        end
        check("sys_start_seen", bus.sys_start, 1);
        tick();
        if (poke) cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
        repeat (3) tick();
        bus.sys_success = succ;
        bus.sys_fail    = fl;
        tick();
        bus.sys_success = 1'b0;
        bus.sys_fail    = 1'b0;
    endtask

    task automatic drain(input bit rnd, output int cycles);
        cycles = 0;
        while (n_done == d0 && cycles < 2000) begin
            bus.m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            cycles++;
        end
        bus.m_ready = 1'b0;
        check("drain_done_seen", n_done, d0 + 1);
    endtask

    task automatic end_checks(input string tag, input int ns, input int nw, input int nr,
                              input logic efail);
        repeat (4) tick();
        check({tag, "_done_once"}, n_done, d0 + 1);
        check({tag, "_starts"}, n_start, s0 + ns);
        check({tag, "_writes"}, n_wr, w0 + nw);
        check({tag, "_reads"}, n_rd, r0 + nr);
        check({tag, "_outputs"}, out_idx, nr);
        check({tag, "_exp_empty"}, exp_q.size(), 0);
        check({tag, "_status"}, status_fail, efail);
        check({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; cmd_start = 1'b0;
        bus.s_valid = 1'b0; bus.s_data = '0;
        bus.sys_success = 1'b0; bus.sys_fail = 1'b0; bus.m_ready = 1'b0;
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_status_fail", status_fail, 0);
        check("rst_state", dbg_state, 0);
        check("rst_s_ready", bus.s_ready, 0);
        check("rst_m_valid", bus.m_valid, 0);
        check("rst_sys_start", bus.sys_start, 0);
        check("rst_rd_en", bus.sys_rd_en, 0);
        rst = 1'b1;
        repeat (2) tick();

        // Back-to-back load, success, unload with m_ready held high.
        snap();
        new_job();
        check("job1_busy", busy, 1);
        check("job1_s_ready", bus.s_ready, 1);
        load(0, 0, 1, 0);
        outcome(1, 0, 0);
        drain(0, cyc);
        check("job1_unload_cycles", cyc, 35);
        end_checks("job1", 1, 32, 32, 0);

        // Random input gaps, random m_ready, cmd_start poked in LOAD and WAIT.
        snap();
        new_job();
        load(7, 1, 1, 1);
        outcome(1, 0, 1);
        drain(1, cyc);
        end_checks("job2", 1, 32, 32, 0);

        // Abort: fail and success together, fail wins.
        snap();
        new_job();
        load(2, 0, 0, 0);
        outcome(1, 1, 0);
        check("fail_done_pulse", done, 1);
        check("fail_status", status_fail, 1);
        check("fail_busy", busy, 0);
        check("fail_state", dbg_state, 0);
        tick();
        check("fail_done_drop", done, 0);
        end_checks("fail", 1, 32, 0, 1);
        check("fail_status_held", status_fail, 1);

        // Next job clears status_fail and runs normally.
        snap();
        new_job();
        check("fail_clear_status", status_fail, 0);
        load(11, 0, 1, 0);
        outcome(1, 0, 0);
        drain(0, cyc);
        end_checks("job4", 1, 32, 32, 0);

        // Reset in the middle of unload.
        snap();
        new_job();
        load(5, 0, 1, 0);
        outcome(1, 0, 0);
        bus.m_ready = 1'b1;
        t = 0;
        while (out_idx < 10 && t < 200) begin
            tick();
            t++;
        end
        check("rst_mid_outputs", out_idx, 10);
        rst = 1'b0;
        #1;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_state", dbg_state, 0);
        check("rst_mid_m_valid", bus.m_valid, 0);
        check("rst_mid_m_data", bus.m_data, 0);
        check("rst_mid_m_last", bus.m_last, 0);
        check("rst_mid_rd_en", bus.sys_rd_en, 0);
        check("rst_mid_rd_addr", bus.sys_rd_addr, 0);
        check("rst_mid_s_ready", bus.s_ready, 0);
        check("rst_mid_wr_en", bus.sys_wr_en, 0);
        check("rst_mid_done", done, 0);
        bus.m_ready = 1'b0;
        exp_q.delete();
        stall_pend = 1'b0;
        tick();
        rst = 1'b1;
        tick();

        snap();
        new_job();
        load(9, 0, 1, 0);
        outcome(1, 0, 0);
        drain(0, cyc);
        end_checks("post_rst", 1, 32, 32, 0);

`ifdef SYSCTRL_RETRY_EN
        // Three failures retried, fourth attempt succeeds.
        snap();
        new_job();
        for (int a = 0; a < 3; a++) begin
            load(a, 0, 0, 0);
            outcome(0, 1, 0);
            check("retry_pulse", retry_req, 1);
            check("retry_no_done", done, 0);
            check("retry_status", status_fail, 0);
            check("retry_state_load", dbg_state, 1);
        end
        load(13, 0, 1, 0);
        outcome(1, 0, 0);
        drain(0, cyc);
        end_checks("retry_ok", 4, 128, 32, 0);
        check("retry_ok_count", n_retry, q0 + 3);

        // Four failures: the last one is fatal.
        snap();
        new_job();
        for (int a = 0; a < 4; a++) begin
            load(a, 0, 0, 0);
            outcome(0, 1, 0);
        end
        check("retry_fatal_done", done, 1);
        check("retry_fatal_status", status_fail, 1);
        end_checks("retry_fatal", 4, 128, 0, 1);
        check("retry_fatal_count", n_retry, q0 + 3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
